// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: rotate right/left, logical and arithmetic shift
// right over a W-bit operand. Stage k applies a 2^k step when amount bit k is
// set. All stages advance together under a single valid/ready stall signal.
module barrel_shifter_pipe #(
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_data,
   input  logic [$clog2(W)-1:0] in_amt,
   input  logic [1:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data
);

   localparam int AW = $clog2(W);
   localparam int S  = AW;

   // One 2^k step. Rotate left is the mirrored index walk, so no amount
   // negation is needed. The power-of-two width makes the AW-bit wrap the modulo.
   function automatic logic [W-1:0] shift_by(input logic [W-1:0] x,
                                              input logic [1:0]   mode,
                                              input logic         sgn,
                                              input int           d);
      logic [W-1:0]  y;
      logic [AW-1:0] up;
      logic [AW-1:0] dn;
      y = '0;
      for (int i = 0; i < W; i++) begin
         up = AW'(i + d);
         dn = AW'(i - d);
         case (mode)
            2'b00:   y[i] = x[up];
            2'b01:   y[i] = x[dn];
            2'b10:   y[i] = (i + d < W) ? x[up] : 1'b0;
            default: y[i] = (i + d < W) ? x[up] : sgn;
         endcase
      end
      return y;
   endfunction

   logic                   advance;

   // Per-stage combinational inputs (stage 0 straight from the ports)
   logic [S-1:0][W-1:0]    st_data;
   logic [S-1:0][1:0]      st_mode;
   logic [S-1:0]           st_sign;
   logic [S-1:0]           st_amt;

   logic [S-1:0][W-1:0]    data_d, data_q;
   logic [S-1:0]           vld_d, vld_q;
   // Side-band carried forward to stages 1..S-1 (last stage needs none)
   logic [S-2:0][1:0]      mode_d, mode_q;
   logic [S-2:0]           sign_d, sign_q;

   // Whole pipe moves when the output slot is empty or being drained
   assign advance   = ~vld_q[S-1] | out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_q[S-1];
   assign out_data  = data_q[S-1];

   // Remaining amount bits shrink by one per stage: the register feeding
   // stage k+1 keeps only bits k+1..AW-1 of the original amount.
   for (genvar k = 0; k < S - 1; k++) begin : g_amt
      logic [AW-k-2:0] amt_src, amt_d, amt_q;
      if (k == 0) begin : g_src
         assign amt_src = in_amt[AW-1:1];
      end else begin : g_src
         assign amt_src = g_amt[k-1].amt_q[AW-k-1:1];
      end

      // Hold the remaining amount while stalled
      always_comb amt_d = advance ? amt_src : amt_q;

      // Remaining-amount register for stage k+1
      always_ff @(posedge clk or posedge reset) begin
         if (reset) amt_q <= '0;
         else       amt_q <= amt_d;
      end
   end

   for (genvar k = 0; k < S; k++) begin : g_stg
      if (k == 0) begin : g_in
         assign st_data[k] = in_data;
         assign st_mode[k] = in_mode;
         assign st_sign[k] = in_data[W-1];
         assign st_amt[k]  = in_amt[0];
      end else begin : g_in
         assign st_data[k] = data_q[k-1];
         assign st_mode[k] = mode_q[k-1];
         assign st_sign[k] = sign_q[k-1];
         assign st_amt[k]  = g_amt[k-1].amt_q[0];
      end
   end

   // Next state of every stage: shifted data on advance, hold otherwise
   always_comb begin
      data_d = data_q;
      for (int k = 0; k < S; k++) begin
         if (advance)
            data_d[k] = st_amt[k] ? shift_by(st_data[k], st_mode[k], st_sign[k], 1 << k)
                                  : st_data[k];
      end
      vld_d  = advance ? {vld_q[S-2:0], in_valid} : vld_q;
      mode_d = advance ? st_mode[S-2:0] : mode_q;
      sign_d = advance ? st_sign[S-2:0] : sign_q;
   end

   // Stage registers; reset empties the pipe and clears the output data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         vld_q  <= '0;
         mode_q <= '0;
         sign_q <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         mode_q <= mode_d;
         sign_q <= sign_d;
      end
   end

endmodule
